// File: rtl/mips_pkg.sv
// Shared constants and types for the mini MIPS datapath.
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/memtoreg_mux.sv
// Writeback source select: load data when sel_i is high, ALU result otherwise.
module memtoreg_mux
    import mips_pkg::*;
(
    input  logic  sel_i,
    input  word_t alu_result_i,
    input  word_t mem_data_i,
    output word_t data_o
);

    assign data_o = sel_i ? mem_data_i : alu_result_i;

endmodule

// File: rtl/regfile_wb.sv
// 32x32 register file with a one-entry writeback stage and a pending-write scoreboard.
// Optional build macro: REGFILE_BYPASS_EN forwards the writeback stage to the read
// ports (and masks busy) for the cycle between capture and commit.
module regfile_wb
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  reg_addr_t rs_addr,
    input  reg_addr_t rt_addr,
    output word_t     rs_data,
    output word_t     rt_data,
    output logic      rs_busy,
    output logic      rt_busy,
    input  logic      issue_valid,
    input  reg_addr_t issue_addr,
    output logic      issue_ready,
    input  logic      wb_valid,
    input  reg_addr_t wb_addr,
    input  logic      wb_memtoreg,
    input  word_t     wb_alu_result,
    input  word_t     wb_mem_data
);

    word_t               regs_q [NUM_REGS];
    word_t               regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                stage_valid_q, stage_valid_d;
    reg_addr_t           stage_addr_q, stage_addr_d;
    word_t               stage_data_q, stage_data_d;
    word_t               wb_sel_data;
    logic                commit;

    memtoreg_mux u_memtoreg_mux (
        .sel_i        (wb_memtoreg),
        .alu_result_i (wb_alu_result),
        .mem_data_i   (wb_mem_data),
        .data_o       (wb_sel_data)
    );

    assign commit      = stage_valid_q && (stage_addr_q != REG_ZERO);
    assign issue_ready = ~pending_q[issue_addr];

    // Next state: capture writeback, commit stage to array, update scoreboard.
    always_comb begin
        stage_valid_d = wb_valid;
        stage_addr_d  = wb_addr;
        stage_data_d  = wb_sel_data;
        regs_d        = regs_q;
        pending_d     = pending_q;
        if (commit) begin
            regs_d[stage_addr_q]    = stage_data_q;
            pending_d[stage_addr_q] = 1'b0;
        end
        // Set after clear so a newly issued producer is never lost.
        if (issue_valid && issue_ready && (issue_addr != REG_ZERO)) begin
            pending_d[issue_addr] = 1'b1;
        end
    end

    // State registers; reset discards in-flight writeback and all pending bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q     <= '0;
            stage_valid_q <= 1'b0;
            stage_addr_q  <= REG_ZERO;
            stage_data_q  <= '0;
        end else begin
            regs_q        <= regs_d;
            pending_q     <= pending_d;
            stage_valid_q <= stage_valid_d;
            stage_addr_q  <= stage_addr_d;
            stage_data_q  <= stage_data_d;
        end
    end

    // Read ports and busy flags; register 0 is never written nor marked pending.
    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
        rs_busy = pending_q[rs_addr];
        rt_busy = pending_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
        if (commit && (stage_addr_q == rs_addr)) begin
            rs_data = stage_data_q;
            rs_busy = 1'b0;
        end
        if (commit && (stage_addr_q == rt_addr)) begin
            rt_data = stage_data_q;
            rt_busy = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: a reference register model plus a queue of
// addresses written back, popped and read through both ports once committed.
module tb_regfile_wb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        rs_busy, rt_busy;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        wb_memtoreg;
    logic [31:0] wb_alu_result, wb_mem_data;

    int          n_checks;
    int          n_pass;
    logic [31:0] model_regs [32];
    logic [4:0]  exp_q [$];

    regfile_wb dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .rs_busy       (rs_busy),
        .rt_busy       (rt_busy),
        .issue_valid   (issue_valid),
        .issue_addr    (issue_addr),
        .issue_ready   (issue_ready),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_memtoreg   (wb_memtoreg),
        .wb_alu_result (wb_alu_result),
        .wb_mem_data   (wb_mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic [4:0] addr, input logic [31:0] alu,
                            input logic [31:0] mem, input logic m2r);
        wb_valid      = 1'b1;
        wb_addr       = addr;
        wb_alu_result = alu;
        wb_mem_data   = mem;
        wb_memtoreg   = m2r;
        if (addr != 5'd0) model_regs[addr] = m2r ? mem : alu;
        exp_q.push_back(addr);
    endtask

    // Pop every committed writeback and read it back on both ports.
    task automatic drain();
        logic [4:0] a;
        while (exp_q.size() > 0) begin
            a       = exp_q.pop_front();
            rs_addr = a;
            rt_addr = a;
            #1;
            check_eq($sformatf("rs_data[%0d]", a), rs_data, model_regs[a]);
            check_eq($sformatf("rt_data[%0d]", a), rt_data, model_regs[a]);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        rst_n         = 1'b0;
        rs_addr       = '0;
        rt_addr       = '0;
        issue_valid   = 1'b0;
        issue_addr    = '0;
        wb_valid      = 1'b0;
        wb_addr       = '0;
        wb_memtoreg   = 1'b0;
        wb_alu_result = '0;
        wb_mem_data   = '0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset with a pending write and a full writeback stage.
        issue_valid = 1'b1;
        issue_addr  = 5'd2;
        step();
        issue_valid = 1'b0;
        drive_wb(5'd2, 32'h55, 32'h0, 1'b0);
        step();
        wb_valid = 1'b0;
        rs_addr  = 5'd2;
        rt_addr  = 5'd2;
        rst_n    = 1'b0;
        #1;
        check_eq("rst_rs_data", rs_data, 32'h0);
        check_eq("rst_rt_data", rt_data, 32'h0);
        check_eq("rst_rs_busy", {31'b0, rs_busy}, 32'h0);
        check_eq("rst_issue_ready", {31'b0, issue_ready}, 32'h1);
        step();
        rst_n = 1'b1;
        model_regs[2] = '0;
        exp_q.delete();
        step();
        check_eq("post_rst_rs_data", rs_data, 32'h0);

        // Issue reg 5 then write back 0xAA through the ALU path.
        issue_valid = 1'b1;
        issue_addr  = 5'd5;
        #1;
        check_eq("issue5_ready", {31'b0, issue_ready}, 32'h1);
        step();
        issue_valid = 1'b0;
        rs_addr     = 5'd5;
        #1;
        check_eq("busy5_after_issue", {31'b0, rs_busy}, 32'h1);
        drive_wb(5'd5, 32'h0000_00AA, 32'h1234_5678, 1'b0);
        step();
        wb_valid = 1'b0;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("r5_between_edges", rs_data, 32'hAA);
        check_eq("busy5_between_edges", {31'b0, rs_busy}, 32'h0);
`else
        check_eq("r5_between_edges", rs_data, 32'h0);
        check_eq("busy5_between_edges", {31'b0, rs_busy}, 32'h1);
`endif
        step();
        check_eq("busy5_after_commit", {31'b0, rs_busy}, 32'h0);
        drain();

        // Load-data path to a register that was never issued.
        drive_wb(5'd9, 32'h1, 32'hDEAD_BEEF, 1'b1);
        step();
        wb_valid = 1'b0;
        step();
        rs_addr = 5'd9;
        #1;
        check_eq("busy9", {31'b0, rs_busy}, 32'h0);
        drain();

        // Register 0: issue and write are both ignored.
        issue_valid = 1'b1;
        issue_addr  = 5'd0;
        drive_wb(5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        #1;
        check_eq("r0_ready_before", {31'b0, issue_ready}, 32'h1);
        step();
        wb_valid = 1'b0;
        rs_addr  = 5'd0;
        #1;
        check_eq("r0_ready_after", {31'b0, issue_ready}, 32'h1);
        check_eq("r0_busy", {31'b0, rs_busy}, 32'h0);
        check_eq("r0_data_stage", rs_data, 32'h0);
        issue_valid = 1'b0;
        step();
        drain();

        // Second issue to reg 7 stalls until its commit edge, accepted the cycle after.
        issue_valid = 1'b1;
        issue_addr  = 5'd7;
        step();
        #1;
        check_eq("r7_second_held", {31'b0, issue_ready}, 32'h0);
        drive_wb(5'd7, 32'h77, 32'h0, 1'b0);
        step();
        wb_valid = 1'b0;
        #1;
        check_eq("r7_held_in_commit_cycle", {31'b0, issue_ready}, 32'h0);
        step();
        check_eq("r7_ready_after_commit", {31'b0, issue_ready}, 32'h1);
        step();
        issue_valid = 1'b0;
        rs_addr     = 5'd7;
        #1;
        check_eq("r7_pending_again", {31'b0, rs_busy}, 32'h1);
        drain();
        drive_wb(5'd7, 32'h78, 32'h0, 1'b0);
        step();
        wb_valid = 1'b0;
        step();
        drain();

        // Back-to-back writes to reg 3; reg 4 issues during reg 3's final commit.
        issue_valid = 1'b1;
        issue_addr  = 5'd3;
        step();
        issue_valid = 1'b0;
        drive_wb(5'd3, 32'h11, 32'h0, 1'b0);
        step();
        drive_wb(5'd3, 32'h22, 32'h0, 1'b0);
        step();
        wb_valid    = 1'b0;
        issue_valid = 1'b1;
        issue_addr  = 5'd4;
        #1;
        check_eq("r4_ready_during_r3_commit", {31'b0, issue_ready}, 32'h1);
        step();
        issue_valid = 1'b0;
        rs_addr     = 5'd3;
        rt_addr     = 5'd4;
        #1;
        check_eq("r3_busy_cleared", {31'b0, rs_busy}, 32'h0);
        check_eq("r4_busy_set", {31'b0, rt_busy}, 32'h1);
        drain();

        // Sustained writebacks every cycle with random data and sources.
        for (int i = 0; i < 10; i++) begin
            drive_wb(5'($urandom_range(31, 0)), $urandom, $urandom, 1'($urandom_range(1, 0)));
            step();
        end
        wb_valid = 1'b0;
        step();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
